// File: rtl/sdf_pkg.sv
// Shared types and timing constants for the radix-2 SDF FFT pipeline.
// Used by the sequencer, the sdf stages and the bench model.
package sdf_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } sdf_state_e;

  // Feedback delay of stage s.
  function automatic int stage_delay(input int n, input int s);
    return n >> (s + 1);
  endfunction

  // Cycle offset of stage s relative to the pipeline input.
  function automatic int stage_off(
    input int n,
    input int lat,
    input int s
  );
    int acc;
    acc = 0;
    for (int i = 0; i < s; i++) begin
      acc += stage_delay(n, i) + lat;
    end
    return acc;
  endfunction

  // Input-to-output latency of the whole chain.
  function automatic int total_lat(input int n, input int lat);
    return stage_off(n, lat, $clog2(n));
  endfunction

endpackage

// File: rtl/sdf_tw_gen.sv
// Twiddle ROM index for the multiplier after stage S.
// Ports: p (phase counter) in, idx (ROM index) out.
module sdf_tw_gen
  import sdf_pkg::*;
#(
  parameter int N   = 64,
  parameter int S   = 0,
  parameter int OFF = 0
) (
  input  logic [$clog2(N)-1:0] p,
  output logic [$clog2(N)-2:0] idx
);

  localparam int LOGN = $clog2(N);
  localparam int TW   = LOGN - 1;

  localparam logic [LOGN-1:0] OFF_M =
    LOGN'(OFF % N);
  localparam logic [LOGN-1:0] MASK =
    LOGN'(stage_delay(N, S) - 1);

  // Output-side count of stage S; OFF is the
  // offset of the stage that follows it.
  logic [LOGN-1:0] o;

  assign o = p - OFF_M;

  // Only the difference half is rotated.
  assign idx = o[LOGN-1-S]
             ? TW'((o & MASK) << S)
             : '0;

endmodule

// File: rtl/sdf_seq_ctrl.sv
// Sequencer for the radix-2 SDF FFT: advance enable, per-stage
// butterfly select and twiddle addresses, output framing, drain/abort.
// Ports: clk, rst_n (sync, low); enable_in/in_ready source handshake;
// ce, zero_in, bf_sel, tw_addr to the datapath; out_valid, out_first
// framing; err_abort pulse; busy.
module sdf_seq_ctrl
  import sdf_pkg::*;
#(
  parameter int N         = 64,
  parameter int STAGE_LAT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable_in,
  output logic in_ready,
  output logic ce,
  output logic zero_in,
  output logic [$clog2(N)-1:0] bf_sel,
  output logic [($clog2(N)-1)*($clog2(N)-1)-1:0] tw_addr,
  output logic out_valid,
  output logic out_first,
  output logic err_abort,
  output logic busy
);

  localparam int LOGN = $clog2(N);
  localparam int TW   = LOGN - 1;
  localparam int L    = total_lat(N, STAGE_LAT);
  localparam int FW   = $clog2(L + 1);
  localparam int OW   = LOGN + 2;

  localparam logic [LOGN-1:0] L_MOD =
    LOGN'(L % N);

  sdf_state_e state;
  logic [LOGN-1:0] p;
  logic [FW-1:0] fill;
  logic [OW-1:0] owed;

  logic p_zero;
  logic acc;
  logic fill_full;
  logic [FW-1:0] fill_nxt;
  logic [OW-1:0] owed_nxt;
  logic [LOGN-1:0] bf_raw;
  logic [TW*TW-1:0] tw_raw;

  assign p_zero    = p == '0;
  assign busy      = state != ST_IDLE;
  assign acc       = enable_in & in_ready;
  assign fill_full = fill == FW'(L);

  always_comb begin
    in_ready = 1'b1;
    ce       = 1'b0;
    zero_in  = 1'b0;
    unique case (state)
      ST_IDLE: begin
        ce = enable_in;
      end
      ST_RUN: begin
        ce      = enable_in | p_zero;
        zero_in = ~enable_in & p_zero;
      end
      ST_DRAIN: begin
        in_ready = p_zero;
        ce       = 1'b1;
        zero_in  = ~(enable_in & p_zero);
      end
      default: ;
    endcase
  end

  assign out_valid = ce & busy & fill_full
                   & (owed != '0);
  assign out_first = out_valid & (p == L_MOD);

  assign fill_nxt = fill_full ? fill
                  : fill + 1'b1;

  // Simultaneous accept and emit leaves owed alone.
  always_comb begin
    owed_nxt = owed;
    unique case ({acc, out_valid})
      2'b10:   owed_nxt = owed + 1'b1;
      2'b01:   owed_nxt = owed - 1'b1;
      default: owed_nxt = owed;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      p         <= '0;
      fill      <= '0;
      owed      <= '0;
      err_abort <= 1'b0;
    end else begin
      err_abort <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (acc) begin
            state <= ST_RUN;
            p     <= LOGN'(1);
            fill  <= FW'(1);
            owed  <= OW'(1);
          end
        end
        ST_RUN: begin
          if (!enable_in && !p_zero) begin
            // Partial frame: throw away
            // everything, including owed bins.
            state     <= ST_IDLE;
            p         <= '0;
            fill      <= '0;
            owed      <= '0;
            err_abort <= 1'b1;
          end else begin
            p    <= p + 1'b1;
            fill <= fill_nxt;
            owed <= owed_nxt;
            if (!enable_in) begin
              state <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          p    <= p + 1'b1;
          fill <= fill_nxt;
          owed <= owed_nxt;
          if (acc) begin
            state <= ST_RUN;
          end else if (owed_nxt == '0) begin
            state <= ST_IDLE;
            p     <= '0;
            fill  <= '0;
          end
        end
        default: begin
          state <= ST_IDLE;
          p     <= '0;
          fill  <= '0;
          owed  <= '0;
        end
      endcase
    end
  end

  // Stage-local count c_s = p - OFF_s; its top
  // relevant bit splits fill and butterfly halves.
  for (genvar s = 0; s < LOGN; s++) begin : g_bf
    localparam logic [LOGN-1:0] OFF_S =
      LOGN'(stage_off(N, STAGE_LAT, s) % N);
    assign bf_raw[s] =
      1'((p - OFF_S) >> (LOGN - 1 - s));
  end

  for (genvar s = 0; s < LOGN - 1; s++) begin : g_tw
    sdf_tw_gen #(
      .N   (N),
      .S   (s),
      .OFF (stage_off(N, STAGE_LAT, s + 1))
    ) u_tw (
      .p   (p),
      .idx (tw_raw[s*TW +: TW])
    );
  end

  assign bf_sel  = busy ? bf_raw : '0;
  assign tw_addr = busy ? tw_raw : '0;

endmodule

// File: tb/tb_sdf_seq_ctrl.sv
// Bench for sdf_seq_ctrl (N=16, STAGE_LAT=1): directed frames plus
// random enable traffic against a cycle model of the sequencing rules.
module tb_sdf_seq_ctrl;

  localparam int N    = 16;
  localparam int LAT  = 1;
  localparam int LOGN = 4;
  localparam int TWW  = (LOGN - 1) * (LOGN - 1);

  logic clk;
  logic rst_n;
  logic enable_in;
  logic in_ready;
  logic ce;
  logic zero_in;
  logic [LOGN-1:0] bf_sel;
  logic [TWW-1:0] tw_addr;
  logic out_valid;
  logic out_first;
  logic err_abort;
  logic busy;

  sdf_seq_ctrl #(
    .N         (N),
    .STAGE_LAT (LAT)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable_in (enable_in),
    .in_ready  (in_ready),
    .ce        (ce),
    .zero_in   (zero_in),
    .bf_sel    (bf_sel),
    .tw_addr   (tw_addr),
    .out_valid (out_valid),
    .out_first (out_first),
    .err_abort (err_abort),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(
    input string tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t",
               tag, got, exp, $time);
    end
  endtask

  // Model state: 0 idle, 1 run, 2 drain.
  int off[LOGN+1];
  int ltot;
  int m_st, m_p, m_fill, m_owed, m_ab;
  int e_acc, e_valid;

  // Per-scenario statistics, from observed outputs.
  int rel, first_v, first_f, n_valid, n_first;
  int cur_run, max_run, n_zero, n_abort, last_busy;

  function automatic int md(input int a);
    return ((a % N) + N) % N;
  endfunction

  task automatic clr_stats();
    rel = 0; first_v = -1; first_f = -1;
    n_valid = 0; n_first = 0; cur_run = 0;
    max_run = 0; n_zero = 0; n_abort = 0;
    last_busy = -1;
  endtask

  task automatic check_outs(input logic en);
    int rdy, c, z, bz, bf, tw, v, f;
    bz  = (m_st != 0) ? 1 : 0;
    rdy = (m_st != 2 || m_p == 0) ? 1 : 0;
    e_acc = (en && rdy) ? 1 : 0;
    c = (m_st == 0) ? e_acc
      : (m_st == 1) ? ((en || m_p == 0) ? 1 : 0)
      : 1;
    z = (m_st == 1) ? ((!en && m_p == 0) ? 1 : 0)
      : (m_st == 2) ? (e_acc ? 0 : 1)
      : 0;
    bf = 0;
    tw = 0;
    if (bz != 0) begin
      for (int s = 0; s < LOGN; s++) begin
        if (((md(m_p - off[s]) >> (LOGN - 1 - s)) & 1) != 0)
          bf += (1 << s);
      end
      for (int s = 0; s < LOGN - 1; s++) begin
        int o, d, fld;
        o = md(m_p - off[s] - (N >> (s + 1)) - LAT);
        d = N >> (s + 1);
        fld = ((o / d) % 2 == 1) ? ((o % d) * (1 << s)) % (N / 2) : 0;
        tw += fld << (s * (LOGN - 1));
      end
    end
    v = (c != 0 && m_fill == ltot && m_owed != 0) ? 1 : 0;
    f = (v != 0 && md(m_p - ltot) == 0) ? 1 : 0;
    e_valid = v;
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("ce", 32'(ce), 32'(c));
    chk("zero_in", 32'(zero_in), 32'(z));
    chk("bf_sel", 32'(bf_sel), 32'(bf));
    chk("tw_addr", 32'(tw_addr), 32'(tw));
    chk("out_valid", 32'(out_valid), 32'(v));
    chk("out_first", 32'(out_first), 32'(f));
    chk("err_abort", 32'(err_abort), 32'(m_ab));
    chk("busy", 32'(busy), 32'(bz));
  endtask

  task automatic model_adv();
    m_p = (m_p + 1) % N;
    if (m_fill < ltot) m_fill++;
    m_owed = m_owed + e_acc - e_valid;
  endtask

  task automatic model_upd(input logic en, input logic rst);
    if (rst) begin
      m_st = 0; m_p = 0; m_fill = 0; m_owed = 0; m_ab = 0;
      return;
    end
    m_ab = 0;
    if (m_st == 0) begin
      if (e_acc != 0) begin
        m_st = 1; m_p = 1; m_fill = 1; m_owed = 1;
      end
    end else if (m_st == 1) begin
      if (!en && m_p != 0) begin
        m_st = 0; m_p = 0; m_fill = 0; m_owed = 0; m_ab = 1;
      end else begin
        model_adv();
        if (!en) m_st = 2;
      end
    end else begin
      model_adv();
      if (e_acc != 0) m_st = 1;
      else if (m_owed == 0) begin
        m_st = 0; m_p = 0; m_fill = 0;
      end
    end
  endtask

  task automatic step(input logic en, input logic rst);
    @(negedge clk);
    enable_in = en;
    rst_n = ~rst;
    #1;
    check_outs(en);
    if (out_valid) begin
      n_valid++;
      cur_run++;
      if (first_v < 0) first_v = rel;
    end else begin
      cur_run = 0;
    end
    if (cur_run > max_run) max_run = cur_run;
    if (out_first) begin
      n_first++;
      if (first_f < 0) first_f = rel;
    end
    if (zero_in) n_zero++;
    if (err_abort) n_abort++;
    if (busy) last_busy = rel;
    @(posedge clk);
    model_upd(en, rst);
    rel++;
  endtask

  task automatic run_en(input int n, input logic en);
    for (int i = 0; i < n; i++) step(en, 1'b0);
  endtask

  initial begin
    off[0] = 0;
    for (int s = 0; s < LOGN; s++)
      off[s+1] = off[s] + (N >> (s + 1)) + LAT;
    ltot = off[LOGN];
    enable_in = 1'b0;
    rst_n = 1'b0;
    m_st = 0; m_p = 0; m_fill = 0; m_owed = 0; m_ab = 0;
    clr_stats();

    // Reset, then the outputs at rest.
    step(1'b0, 1'b1);
    step(1'b1, 1'b1);
    run_en(3, 1'b0);

    // Single frame.
    clr_stats();
    run_en(16, 1'b1);
    run_en(25, 1'b0);
    chk("sf_first_valid", 32'(first_v), 32'd19);
    chk("sf_first_first", 32'(first_f), 32'd19);
    chk("sf_valid_cnt", 32'(n_valid), 32'd16);
    chk("sf_zero_cnt", 32'(n_zero), 32'd19);
    chk("sf_idle_at", 32'(last_busy + 1), 32'd35);

    // Three back-to-back frames.
    clr_stats();
    run_en(48, 1'b1);
    run_en(25, 1'b0);
    chk("b2b_run", 32'(max_run), 32'd48);
    chk("b2b_first_cnt", 32'(n_first), 32'd3);
    chk("b2b_first_valid", 32'(first_v), 32'd19);

    // Abort after 5 samples.
    clr_stats();
    run_en(5, 1'b1);
    run_en(25, 1'b0);
    chk("abort_pulses", 32'(n_abort), 32'd1);
    chk("abort_valid", 32'(n_valid), 32'd0);
    chk("abort_idle_at", 32'(last_busy + 1), 32'd6);

    // Re-entry three cycles into drain; source holds enable.
    clr_stats();
    run_en(16, 1'b1);
    run_en(3, 1'b0);
    run_en(29, 1'b1);
    run_en(25, 1'b0);
    chk("reent_valid", 32'(n_valid), 32'd32);
    chk("reent_run", 32'(max_run), 32'd32);

    // Reset at sample 9, then a fresh frame.
    clr_stats();
    run_en(9, 1'b1);
    step(1'b1, 1'b1);
    run_en(2, 1'b0);
    chk("rst_mid_abort", 32'(n_abort), 32'd0);
    clr_stats();
    run_en(16, 1'b1);
    run_en(25, 1'b0);
    chk("rst_first_valid", 32'(first_v), 32'd19);
    chk("rst_valid_cnt", 32'(n_valid), 32'd16);

    // Random traffic, rare resets.
    for (int i = 0; i < 3000; i++) begin
      logic en, rs;
      en = ($urandom_range(0, 99) < 96);
      rs = ($urandom_range(0, 999) < 3);
      step(en, rs);
    end
    run_en(40, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/sdf_seq_ctrl.md
# sdf_seq_ctrl

Sequencer for the radix-2 single-path delay-feedback (SDF) FFT pipeline. It sits between the sample source and the chain of `sdf` stages and owns all pipeline timing: the global advance enable, per-stage butterfly/feedback select, per-stage twiddle addresses, and output framing. It also flushes the last frame with zero input and recovers from frames aborted mid-stream. The datapath stages stay free of their own counters.

## Interface
- `N`, 64: FFT size; power of two, ≥4. LOGN = $clog2(N).
- `STAGE_LAT`, 1: register latency of one butterfly stage, in cycles.
- Derived constants:
  - Stage delays: D_s = N>>(s+1), for s = 0..LOGN-1.
  - Stage offsets: OFF_0 = 0; OFF_s+1 = OFF_s + D_s + STAGE_LAT.
  - Total latency: L = OFF_LOGN.

Ports:
- `clk`  in  1  clock; all state changes on the rising edge.
- `rst_n`  in  1  synchronous, active-low reset.
- `enable_in`  in  1  source offers a sample this cycle.
- `in_ready`  out  1  controller accepts a sample this cycle.
- `ce`  out  1  pipeline advance; every delay line and stage register updates only when `ce`=1.
- `zero_in`  out  1  datapath substitutes 0+0j for the input sample.
- `bf_sel`  out  LOGN  bit s=1 means stage s is in butterfly phase (feedback = difference output); bit s=0 means fill phase.
- `tw_addr`  out  (LOGN-1)*(LOGN-1)  field s (s=0..LOGN-2) is the twiddle ROM index for the multiplier after stage s.
- `out_valid`  out  1  final-stage output is a real FFT bin.
- `out_first`  out  1  first bin of an output frame; only asserted with `out_valid`.
- `err_abort`  out  1  one-cycle pulse: a frame was aborted.
- `busy`  out  1  state ≠ IDLE.

## Operation
- Accepted sample: `acc` = `enable_in` & `in_ready`.
- Registers:
  - `p` (LOGN bits): phase counter, increments on `ce`, wraps mod N.
  - `fill`: saturates at L, increments on `ce`.
  - `owed` (LOGN+2 bits): outputs still due. +1 on `acc`, −1 on `out_valid`; unchanged when both occur.
- States:
  - IDLE
    - `in_ready`=1, `ce`=`acc`.
    - On `acc`: p←1, fill←1, owed←1, go to RUN.
  - RUN
    - `in_ready`=1.
    - `enable_in`=1: `ce`=1, `zero_in`=0.
    - `enable_in`=0 with p=0 (frame boundary): `ce`=1, `zero_in`=1, go to DRAIN.
    - `enable_in`=0 with p≠0: abort. Next cycle `err_abort`=1, state IDLE, p/fill/owed cleared. Partial frame produces no `out_valid`.
  - DRAIN
    - `ce`=1.
    - `in_ready`=(p=0).
    - `zero_in`=~`acc`.
    - `acc` moves to RUN with no bubble.
    - owed=0 (after decrement) moves to IDLE.
    - `enable_in` while p≠0 is not accepted; the source must hold it.
- Stage-local count: c_s = (p − OFF_s) mod N.
- `bf_sel[s]` = c_s[LOGN-1-s].
- Twiddle address:
  - Output-side count: o_s = (p − OFF_s − D_s − STAGE_LAT) mod N.
  - Field s = o_s[LOGN-1-s] ? ((o_s mod D_s) << s) truncated to LOGN-1 : 0.
- `out_valid` = `ce` & (fill=L) & (owed≠0).
- `out_first` = `out_valid` & ((p − L) mod N = 0).
- Outputs are bit-reversed order; reordering is outside this block.

## Timing
- Reset: state IDLE, p=0, fill=0, owed=0.
  - Outputs after reset: `in_ready`=1, `ce`=0, `zero_in`=0, `bf_sel`=0, `tw_addr`=0, `out_valid`=0, `out_first`=0, `err_abort`=0, `busy`=0.
- `rst_n` low mid-frame has the same effect; no `err_abort` is generated.
- `ce`, `in_ready`, `zero_in` are combinational from state, p and `enable_in`. They must reach the datapath in the same cycle.
- `bf_sel`, `tw_addr`, `out_valid`, `out_first` are combinational from registered counters. All are forced to 0 in IDLE.
- `err_abort` is registered and lasts exactly one cycle.
- Latency: the first accepted sample at cycle t gives `out_valid` and `out_first` at cycle t+L. A frame yields exactly N consecutive valid cycles.
- Back-to-back frames: `out_valid` stays high continuously.
- Drain lasts exactly L cycles after the last accepted sample, then IDLE.
- p wrap, owed ±1 in the same cycle, and the DRAIN→RUN re-entry cycle each proceed without a lost `ce` cycle.

## Structure
- Package `sdf_pkg`:
  - State enum (IDLE/RUN/DRAIN).
  - Constant functions for D_s, OFF_s and L.
  - Shared by `sdf` stages and the bench model.
- Sub-module `sdf_tw_gen`, one per stage via generate: o_s → twiddle index.
- Counters and FSM stay in `sdf_seq_ctrl`.

## Test plan
(N=16, STAGE_LAT=1 ⇒ OFF = 0, 9, 14, 17; L=19.)
- Single frame: 16 accepted samples, then `enable_in`=0 → 19 drain cycles with `zero_in`=1. `out_valid` high in cycles 19..34 after the first sample; `out_first` at cycle 19; IDLE at cycle 35.
- Three back-to-back frames (48 samples): `out_valid` high 48 consecutive cycles, with `out_first` every 16 cycles. Check `bf_sel[0]` toggles every 8 cycles and `bf_sel[3]` every cycle (after offset 17).
- Abort: `enable_in` drops after 5 samples → `err_abort`=1 for one cycle, then IDLE. No `out_valid` ever; owed=0.
- Re-entry: frame, then `enable_in` reasserted 3 cycles into DRAIN → `in_ready`=0 until p=0 (cycle 16 of drain). Accepted there, then 32 contiguous valid outputs.
- Twiddle: stage 0 second-half outputs give field 0 = 0..7, and 0 during sum outputs. Field 1 = 0, 2, 4, 6.
- Reset mid-RUN: `rst_n`=0 for 1 cycle at sample 9 → all outputs at their reset values next cycle. A new frame then gives first `out_valid` 19 cycles after its first sample.
